regfile_wb_queue: RTL and testbench

Write-back queue in front of the single write port of the SEQ core's 32×32 register file. It accepts results from two producers: port A is the single-cycle ALU path and port B is the load/multi-cycle path. It queues the results in program-priority order and drains exactly one register write per cycle into the register file's `reg_write`/`rd`/`write_data` inputs. It also exports a per-register busy vector so decode can stall on a read-after-write hazard against a not-yet-written result.

---
 rtl/regfile_wb_queue.sv | 87 ++++++++
 tb/tb_regfile_wb_queue.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the single register-file write port from two producers
// (A: ALU, B: load/multi-cycle), retiring one entry per cycle and exporting a busy vector.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [4:0]                 a_rd,
  input  logic [XLEN-1:0]            a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [4:0]                 b_rd,
  input  logic [XLEN-1:0]            b_data,
  output logic                       reg_write,
  output logic [4:0]                 rd,
  output logic [XLEN-1:0]            write_data,
  output logic [31:0]                busy,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [PW-1:0]   wptr, rptr, b_slot;
  logic [CW-1:0]   free, pushes;
  logic            a_fire, b_fire, a_push, b_push, pop;

  // Free space ignores the same-cycle pop so ready never depends on the retire path.
  assign free    = CW'(DEPTH) - count;
  assign a_ready = !rst && !flush && (free >= CW'(1));
  assign b_ready = !rst && !flush && ((free >= CW'(2)) || ((free >= CW'(1)) && !a_valid));

  assign a_fire = a_valid && a_ready;
  assign b_fire = b_valid && b_ready;
  assign a_push = a_fire && (a_rd != 5'd0);
  assign b_push = b_fire && (b_rd != 5'd0);
  assign b_slot = wptr + PW'(a_push);
  assign pushes = CW'(a_push) + CW'(b_push);
  assign pop    = reg_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else if (flush) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      count <= count + pushes - CW'(pop);
      wptr  <= wptr + PW'(pushes);
      rptr  <= rptr + PW'(pop);
    end
  end

  // Entry storage is data only; validity is carried entirely by count.
  always_ff @(posedge clk) begin
    if (a_push) begin
      rd_mem[wptr]   <= a_rd;
      data_mem[wptr] <= a_data;
    end
    if (b_push) begin
      rd_mem[b_slot]   <= b_rd;
      data_mem[b_slot] <= b_data;
    end
  end

  assign reg_write  = (count != '0);
  assign rd         = reg_write ? rd_mem[rptr]   : 5'd0;
  assign write_data = reg_write ? data_mem[rptr] : '0;

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) busy[rd_mem[rptr + PW'(i)]] = 1'b1;
    end
    busy[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios plus random traffic checked
// every cycle against a queue-based reference model.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic             clk, rst, flush;
  logic             a_valid, a_ready, b_valid, b_ready;
  logic [4:0]       a_rd, b_rd, rd;
  logic [XLEN-1:0]  a_data, b_data, write_data;
  logic             reg_write;
  logic [31:0]      busy;
  logic [$clog2(DEPTH):0] count;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   retired  = 0;

  regfile_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .reg_write(reg_write), .rd(rd), .write_data(write_data),
    .busy(busy), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [XLEN-1:0] bd,
                       input logic fl);
    int          free;
    logic        ear, ebr;
    logic [31:0] eb;
    @(negedge clk);
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    flush = fl;
    #1;
    free = DEPTH - q.size();
    ear  = !fl && (free >= 1);
    ebr  = !fl && ((free >= 2) || ((free >= 1) && !av));
    eb   = '0;
    foreach (q[i]) eb[q[i].rd] = 1'b1;
    eb[0] = 1'b0;
    chk("reg_write",  64'(reg_write),  64'(q.size() != 0));
    chk("rd",         64'(rd),         (q.size() != 0) ? 64'(q[0].rd) : 64'd0);
    chk("write_data", 64'(write_data), (q.size() != 0) ? 64'(q[0].data) : 64'd0);
    chk("count",      64'(count),      64'(q.size()));
    chk("busy",       64'(busy),       64'(eb));
    chk("a_ready",    64'(a_ready),    64'(ear));
    chk("b_ready",    64'(b_ready),    64'(ebr));
    @(posedge clk);
    if (q.size() != 0) begin
      void'(q.pop_front());
      retired++;
    end
    if (fl) q.delete();
    else begin
      if (av && ear && ard != 5'd0) q.push_back('{rd: ard, data: ad});
      if (bv && ebr && brd != 5'd0) q.push_back('{rd: brd, data: bd});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
  endtask

  initial begin
    logic            av, bv, fl;
    logic [4:0]      ard, brd;
    logic [XLEN-1:0] ad, bd;

    rst = 1'b1; flush = 1'b0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    #1;
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_a_ready",   64'(a_ready),   64'd0);
    chk("rst_b_ready",   64'(b_ready),   64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single A write
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0, 1'b0);
    idle(2);

    // Dual push to the same register
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 1'b0);
    idle(3);

    // x0 filter
    cycle(1'b1, 5'd0, 32'hFF, 1'b1, 5'd7, 32'h44, 1'b0);
    idle(2);

    // Backpressure and pointer wrap
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b1, 5'(i + 16), 32'h200 + 32'(i), 1'b0);
    idle(5);

    // Flush with three entries queued
    cycle(1'b1, 5'd9, 32'hA1, 1'b1, 5'd10, 32'hA2, 1'b0);
    cycle(1'b1, 5'd11, 32'hA3, 1'b1, 5'd12, 32'hA4, 1'b0);
    cycle(1'b1, 5'd13, 32'hA5, 1'b0, 5'd0, '0, 1'b1);
    idle(3);

    // Asynchronous reset mid-cycle with three entries queued
    cycle(1'b1, 5'd1, 32'hB1, 1'b1, 5'd2, 32'hB2, 1'b0);
    cycle(1'b1, 5'd3, 32'hB3, 1'b1, 5'd4, 32'hB4, 1'b0);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0;
    #1;
    chk("pre_rst_count", 64'(count), 64'(q.size()));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_reg_write", 64'(reg_write), 64'd0);
    chk("async_rst_count",     64'(count),     64'd0);
    chk("async_rst_busy",      64'(busy),      64'd0);
    chk("async_rst_a_ready",   64'(a_ready),   64'd0);
    chk("async_rst_b_ready",   64'(b_ready),   64'd0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      av  = 1'($urandom_range(0, 1));
      bv  = 1'($urandom_range(0, 1));
      ard = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      brd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ad  = $urandom;
      bd  = $urandom;
      fl  = ($urandom_range(0, 29) == 0);
      cycle(av, ard, ad, bv, brd, bd, fl);
    end
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
